// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational for the IF stage and training arrives
// from the ID stage. The optional statistics counters are built only when
// the BP_STATS_EN macro is defined.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CTR_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lk_en_i,
  input  logic [ADDR_W-1:0] lk_pc_i,
  output logic              lk_hit_o,
  output logic              lk_taken_o,
  output logic [ADDR_W-1:0] lk_target_o,
  input  logic              up_valid_i,
  input  logic [ADDR_W-1:0] up_pc_i,
  input  logic              up_taken_i,
  input  logic [ADDR_W-1:0] up_target_i,
  input  logic              up_pred_taken_i,
  input  logic [ADDR_W-1:0] up_pred_target_i,
  output logic              mispredict_o,
  input  logic              flush_all_i
`ifdef BP_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [31:0]       stat_lookups_o,
  output logic [31:0]       stat_mispred_o
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [CTR_W-1:0] up_ctr_nxt;

  // Byte-offset bits never address the table; lk_en_i only feeds the stats.
  logic unused_bits;
  assign unused_bits = ^{lk_pc_i[1:0], up_pc_i[1:0], lk_en_i};

  assign lk_idx = lk_pc_i[IDX_W+1:2];
  assign lk_tag = lk_pc_i[ADDR_W-1:IDX_W+2];
  assign up_idx = up_pc_i[IDX_W+1:2];
  assign up_tag = up_pc_i[ADDR_W-1:IDX_W+2];

  // Same-cycle lookup: reads registered state only, so no update bypass.
  always_comb begin
    lk_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken_o  = lk_hit_o && ctr_q[lk_idx][CTR_W-1];
    lk_target_o = lk_taken_o ? target_q[lk_idx] : lk_pc_i + ADDR_W'(4);
  end

  // Redirect when direction differs, or when taken to a different target.
  always_comb begin
    mispredict_o = up_valid_i &&
                   ((up_pred_taken_i != up_taken_i) ||
                    (up_taken_i && (up_pred_target_i != up_target_i)));
  end

  // Training side: hit detection and saturating counter step.
  always_comb begin
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr_nxt = ctr_q[up_idx];
    if (up_taken_i) begin
      if (ctr_q[up_idx] != CTR_MAX) up_ctr_nxt = ctr_q[up_idx] + CTR_W'(1);
    end else begin
      if (ctr_q[up_idx] != '0) up_ctr_nxt = ctr_q[up_idx] - CTR_W'(1);
    end
  end

  // Table state: reset, then flush, then training, in that priority.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (flush_all_i) begin
      valid_q <= '0;
    end else if (up_valid_i) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_nxt;
        if (up_taken_i) target_q[up_idx] <= up_target_i;
      end else if (up_taken_i) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= up_target_i;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  // Lookup and mispredict counters; clear beats increment, flush is ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat_lookups_o <= '0;
      stat_mispred_o <= '0;
    end else if (stat_clr_i) begin
      stat_lookups_o <= '0;
      stat_mispred_o <= '0;
    end else begin
      if (lk_en_i)      stat_lookups_o <= stat_lookups_o + 32'd1;
      if (mispredict_o) stat_mispred_o <= stat_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default parameters). Stats checks are
// compiled only when BP_STATS_EN is defined.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lk_en_i;
  logic [31:0] lk_pc_i;
  logic        lk_hit_o;
  logic        lk_taken_o;
  logic [31:0] lk_target_o;
  logic        up_valid_i;
  logic [31:0] up_pc_i;
  logic        up_taken_i;
  logic [31:0] up_target_i;
  logic        up_pred_taken_i;
  logic [31:0] up_pred_target_i;
  logic        mispredict_o;
  logic        flush_all_i;
`ifdef BP_STATS_EN
  logic        stat_clr_i;
  logic [31:0] stat_lookups_o;
  logic [31:0] stat_mispred_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .lk_en_i          (lk_en_i),
    .lk_pc_i          (lk_pc_i),
    .lk_hit_o         (lk_hit_o),
    .lk_taken_o       (lk_taken_o),
    .lk_target_o      (lk_target_o),
    .up_valid_i       (up_valid_i),
    .up_pc_i          (up_pc_i),
    .up_taken_i       (up_taken_i),
    .up_target_i      (up_target_i),
    .up_pred_taken_i  (up_pred_taken_i),
    .up_pred_target_i (up_pred_target_i),
    .mispredict_o     (mispredict_o),
    .flush_all_i      (flush_all_i)
`ifdef BP_STATS_EN
    ,
    .stat_clr_i       (stat_clr_i),
    .stat_lookups_o   (stat_lookups_o),
    .stat_mispred_o   (stat_mispred_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    up_valid_i       = 1'b1;
    up_pc_i          = pc;
    up_taken_i       = tk;
    up_target_i      = tgt;
    up_pred_taken_i  = ptk;
    up_pred_target_i = ptgt;
  endtask

  task automatic idle();
    up_valid_i = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    lk_pc_i = pc;
    #1;
    check({tag, "_hit"},    32'(lk_hit_o),   32'(hit));
    check({tag, "_taken"},  32'(lk_taken_o), 32'(tk));
    check({tag, "_target"}, lk_target_o,     tgt);
  endtask

  initial begin
    rst_i = 1'b0; lk_en_i = 1'b0; lk_pc_i = '0; flush_all_i = 1'b0;
    up_valid_i = 1'b0; up_pc_i = '0; up_taken_i = 1'b0; up_target_i = '0;
    up_pred_taken_i = 1'b0; up_pred_target_i = '0;
`ifdef BP_STATS_EN
    stat_clr_i = 1'b0;
`endif
    #1;
    look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
    check("rst_mispred", 32'(mispredict_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Allocate 0x40 -> 0x100 from a mispredicted not-taken guess.
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    #1;
    check("alloc_mispred", 32'(mispredict_o), 32'd1);
    tick(); idle();
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

    // Counter walk: 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01.
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); tick(); idle();
    look("ctr01", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44); tick(); idle();
    look("ctr00", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44); tick(); idle();
    look("inc01", 32'h40, 1'b1, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44); tick(); idle();
    look("inc10", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); tick(); idle();
    look("inc11", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); tick(); idle();
    look("sat11", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); tick(); idle();
    look("dec10", 32'h40, 1'b1, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    #1;
    check("nt_correct_mispred", 32'(mispredict_o), 32'd0);
    tick(); idle();
    look("dec01", 32'h40, 1'b1, 1'b0, 32'h44);

    // Alias on index 0; concurrent lookup sees pre-update state.
    upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    look("alias_same_cycle", 32'h80, 1'b0, 1'b0, 32'h84);
    tick(); idle();
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias_new", 32'h80, 1'b1, 1'b1, 32'h200);

    // Flush discards a concurrent update.
    flush_all_i = 1'b1;
    upd(32'h10, 1'b1, 32'h500, 1'b0, 32'h14);
    tick(); idle(); flush_all_i = 1'b0;
    look("flush_10", 32'h10, 1'b0, 1'b0, 32'h14);
    look("flush_40", 32'h40, 1'b0, 1'b0, 32'h44);
    look("flush_80", 32'h80, 1'b0, 1'b0, 32'h84);

    // Asynchronous reset in the middle of a cycle.
    upd(32'h40, 1'b1, 32'h300, 1'b0, 32'h44); tick(); idle();
    look("pre_rst", 32'h40, 1'b1, 1'b1, 32'h300);
    #1;
    rst_i = 1'b0;
    look("async_rst", 32'h40, 1'b0, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
    #1;
    check("rst_mispred_comb", 32'(mispredict_o), 32'd1);
    idle();
`ifdef BP_STATS_EN
    check("rst_stat_lk", stat_lookups_o, 32'd0);
    check("rst_stat_mp", stat_mispred_o, 32'd0);
`endif
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    look("post_rst", 32'h40, 1'b0, 1'b0, 32'h44);

`ifdef BP_STATS_EN
    // 10 enabled lookups, 3 mispredicting updates among them.
    lk_en_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 7) upd(32'h20, 1'b1, 32'h600, 1'b0, 32'h24);
      else idle();
      tick();
    end
    lk_en_i = 1'b0; idle();
    #1;
    check("stat_lookups", stat_lookups_o, 32'd10);
    check("stat_mispred", stat_mispred_o, 32'd3);
    stat_clr_i = 1'b1; lk_en_i = 1'b1;
    upd(32'h20, 1'b1, 32'h600, 1'b0, 32'h24);
    tick();
    stat_clr_i = 1'b0; lk_en_i = 1'b0; idle();
    #1;
    check("clr_lookups", stat_lookups_o, 32'd0);
    check("clr_mispred", stat_mispred_o, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
